// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the shared response bus and the shared ALU hookup
// of the ALU arbiter into one interface.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req0_op;
    logic [3:0]  req1_op;

    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_f;
    logic        alu_zero;

    logic        busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        input  rsp0_ready, rsp1_ready,
        input  alu_f, alu_zero,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_sel,
        output busy
    );

    // Requester / ALU side
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        output rsp0_ready, rsp1_ready,
        output alu_f, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_sel,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a single transaction in flight (IDLE -> EXEC -> RESP).
module alu_arbiter #(
    parameter int unsigned RR_INIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic LAST_INIT = (RR_INIT != 0);
    localparam logic [3:0] MAX_LEGAL_OP = 4'd8;

    state_t      state_q,      state_d;
    logic        lastServed_q, lastServed_d;
    logic        owner_q,      owner_d;
    logic [31:0] aluA_q,       aluA_d;
    logic [31:0] aluB_q,       aluB_d;
    logic [3:0]  aluSel_q,     aluSel_d;
    logic [31:0] rspData_q,    rspData_d;
    logic        rspZero_q,    rspZero_d;
    logic        rspErr_q,     rspErr_d;

    logic grant;
    logic req0Ready;
    logic req1Ready;
    logic accept;
    logic ownerRspReady;

    // Sole valid requester wins; on contention the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~lastServed_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst_n so that it drops as soon as reset is asserted.
    assign req0Ready     = rst_n && (state_q == IDLE) && bus.req0_valid && !grant;
    assign req1Ready     = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant;
    assign accept        = req0Ready || req1Ready;
    assign ownerRspReady = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d      = state_q;
        lastServed_d = lastServed_q;
        owner_d      = owner_q;
        aluA_d       = aluA_q;
        aluB_d       = aluB_q;
        aluSel_d     = aluSel_q;
        rspData_d    = rspData_q;
        rspZero_d    = rspZero_q;
        rspErr_d     = rspErr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = EXEC;
                    owner_d  = grant;
                    aluA_d   = grant ? bus.req1_a  : bus.req0_a;
                    aluB_d   = grant ? bus.req1_b  : bus.req0_b;
                    aluSel_d = grant ? bus.req1_op : bus.req0_op;
                end
            end
            EXEC: begin
                state_d = RESP;
                // Selects above SLTU are not ALU operations; report them and ignore alu_f.
                if (aluSel_q > MAX_LEGAL_OP) begin
                    rspData_d = 32'd0;
                    rspZero_d = 1'b1;
                    rspErr_d  = 1'b1;
                end else begin
                    rspData_d = bus.alu_f;
                    rspZero_d = bus.alu_zero;
                    rspErr_d  = 1'b0;
                end
            end
            RESP: begin
                if (ownerRspReady) begin
                    state_d      = IDLE;
                    lastServed_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lastServed_q <= LAST_INIT;
            owner_q      <= 1'b0;
            aluA_q       <= 32'd0;
            aluB_q       <= 32'd0;
            aluSel_q     <= 4'd0;
            rspData_q    <= 32'd0;
            rspZero_q    <= 1'b0;
            rspErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastServed_q <= lastServed_d;
            owner_q      <= owner_d;
            aluA_q       <= aluA_d;
            aluB_q       <= aluB_d;
            aluSel_q     <= aluSel_d;
            rspData_q    <= rspData_d;
            rspZero_q    <= rspZero_d;
            rspErr_q     <= rspErr_d;
        end
    end

    assign bus.req0_ready = req0Ready;
    assign bus.req1_ready = req1Ready;
    assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
    assign bus.rsp_data   = rspData_q;
    assign bus.rsp_zero   = rspZero_q;
    assign bus.rsp_err    = rspErr_q;
    assign bus.alu_a      = aluA_q;
    assign bus.alu_b      = aluB_q;
    assign bus.alu_sel    = aluSel_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
